// File: rtl/wormhole_switch_allocator_if.sv
// Flit ingress/egress bundle of the wormhole switch allocator.
// slave = allocator side, master = input ports / link drivers side.
interface wormhole_switch_allocator_if #(
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int REQUEST_WIDTH = $clog2(OUTPUTS)
);
    logic [INPUTS*DATA_WIDTH-1:0]     data_in_bus;
    logic [INPUTS-1:0]                valid_in_bus;
    logic [INPUTS-1:0]                ready_in_bus;
    logic [INPUTS*REQUEST_WIDTH-1:0]  route_req;
    logic [OUTPUTS*DATA_WIDTH-1:0]    data_out_port;
    logic [OUTPUTS-1:0]               valid_out_port;
    logic [OUTPUTS-1:0]               ready_out_port;
    logic [OUTPUTS*REQUEST_WIDTH-1:0] routeSelect;
    logic [OUTPUTS-1:0]               outputBusy;
    logic [INPUTS-1:0]                PortReserved;

    modport master (
        output data_in_bus, valid_in_bus, route_req, ready_out_port,
        input  ready_in_bus, data_out_port, valid_out_port,
        input  routeSelect, outputBusy, PortReserved
    );

    modport slave (
        input  data_in_bus, valid_in_bus, route_req, ready_out_port,
        output ready_in_bus, data_out_port, valid_out_port,
        output routeSelect, outputBusy, PortReserved
    );
endinterface

// File: rtl/wormhole_switch_allocator.sv
// Round-robin wormhole switch allocator with per-output path locks
// and a one-entry valid/ready register slice on every output.
module wormhole_switch_allocator #(
    parameter int INPUTS        = 4,
    parameter int OUTPUTS       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int TYPE_WIDTH    = 2,
    parameter int REQUEST_WIDTH = $clog2(OUTPUTS)
) (
    input logic clk,
    input logic rst,
    wormhole_switch_allocator_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int RW = REQUEST_WIDTH;
    localparam int TW = TYPE_WIDTH;
    localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    localparam logic [TW-1:0] T_HEADTAIL = TW'(0);
    localparam logic [TW-1:0] T_HEAD     = TW'(1);
    localparam logic [TW-1:0] T_TAIL     = TW'(3);

    logic [DW-1:0]      w_din   [INPUTS];
    logic [RW-1:0]      w_route [INPUTS];
    logic [INPUTS-1:0]  w_head;
    logic [INPUTS-1:0]  w_last;
    logic [INPUTS-1:0]  w_rdy;
    logic [INPUTS-1:0]  w_xfer;
    logic [INPUTS-1:0]  w_resv_nxt;
    logic [OUTPUTS-1:0] w_slot_rdy;
    logic [OUTPUTS-1:0] w_load;
    logic [OUTPUTS-1:0] w_rel;
    logic [OUTPUTS-1:0] w_gnt;
    logic [IW-1:0]      w_win   [OUTPUTS];

    logic [OUTPUTS-1:0] r_busy;
    logic [OUTPUTS-1:0] r_vout;
    logic [INPUTS-1:0]  r_resv;
    logic [RW-1:0]      r_sel   [OUTPUTS];
    logic [IW-1:0]      r_ptr   [OUTPUTS];
    logic [DW-1:0]      r_dout  [OUTPUTS];
    logic [RW-1:0]      r_port  [INPUTS];

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            w_din[i]   = bus.data_in_bus[i*DW +: DW];
            w_route[i] = bus.route_req[i*RW +: RW];
            w_head[i]  = bus.valid_in_bus[i] && !r_resv[i] &&
                         ((w_din[i][DW-1 -: TW] == T_HEAD) ||
                          (w_din[i][DW-1 -: TW] == T_HEADTAIL));
            w_last[i]  = (w_din[i][DW-1 -: TW] == T_TAIL) ||
                         (w_din[i][DW-1 -: TW] == T_HEADTAIL);
        end
    end

    // A reserved input only moves when the slot of its locked output can take a flit.
    always_comb begin
        for (int o = 0; o < OUTPUTS; o++) begin
            w_slot_rdy[o] = !r_vout[o] || bus.ready_out_port[o];
        end
        for (int i = 0; i < INPUTS; i++) begin
            w_rdy[i]  = r_resv[i] && w_slot_rdy[r_port[i]];
            w_xfer[i] = w_rdy[i] && bus.valid_in_bus[i];
        end
        for (int o = 0; o < OUTPUTS; o++) begin
            w_load[o] = r_busy[o] && w_xfer[r_sel[o]];
            w_rel[o]  = w_load[o] && w_last[r_sel[o]];
        end
    end

    always_comb begin : p_arb
        int idx;
        idx = 0;
        for (int o = 0; o < OUTPUTS; o++) begin
            w_gnt[o] = 1'b0;
            w_win[o] = '0;
            if (!r_busy[o]) begin
                for (int k = 0; k < INPUTS; k++) begin
                    idx = (int'(r_ptr[o]) + k) % INPUTS;
                    if (!w_gnt[o] && w_head[idx] &&
                        int'(w_route[idx]) == o) begin
                        w_gnt[o] = 1'b1;
                        w_win[o] = IW'(idx);
                    end
                end
            end
        end
    end

    // Grants and releases never touch the same input in one cycle.
    always_comb begin
        w_resv_nxt = r_resv;
        for (int o = 0; o < OUTPUTS; o++) begin
            if (w_gnt[o]) w_resv_nxt[w_win[o]] = 1'b1;
        end
        for (int o = 0; o < OUTPUTS; o++) begin
            if (w_rel[o]) w_resv_nxt[r_sel[o]] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            r_vout <= '0;
            r_resv <= '0;
            for (int o = 0; o < OUTPUTS; o++) begin
                r_sel[o]  <= '0;
                r_ptr[o]  <= '0;
                r_dout[o] <= '0;
            end
            for (int i = 0; i < INPUTS; i++) begin
                r_port[i] <= '0;
            end
        end else begin
            r_resv <= w_resv_nxt;
            for (int o = 0; o < OUTPUTS; o++) begin
                if (w_gnt[o]) begin
                    r_busy[o]        <= 1'b1;
                    r_sel[o]         <= RW'(w_win[o]);
                    r_ptr[o]         <= IW'((int'(w_win[o]) + 1) % INPUTS);
                    r_port[w_win[o]] <= RW'(o);
                end else if (w_rel[o]) begin
                    r_busy[o] <= 1'b0;
                end
                if (w_load[o]) begin
                    r_vout[o] <= 1'b1;
                    r_dout[o] <= w_din[r_sel[o]];
                end else if (bus.ready_out_port[o]) begin
                    r_vout[o] <= 1'b0;
                end
            end
        end
    end

    for (genvar o = 0; o < OUTPUTS; o++) begin : g_out
        assign bus.data_out_port[o*DW +: DW] = r_dout[o];
        assign bus.routeSelect[o*RW +: RW]   = r_sel[o];
    end

    assign bus.valid_out_port = r_vout;
    assign bus.outputBusy     = r_busy;
    assign bus.PortReserved   = r_resv;
    assign bus.ready_in_bus   = w_rdy;
endmodule
